// File: rtl/skinny_tbc.sv
// skinny_tbc: iterative SKINNY-128-384+ core, numrnd rounds per cycle behind valid/ready handshakes.
// Cell 0 of every 128-bit word is its most significant byte.
module skinny_rnd #(
  parameter int numrnd = 2,
  parameter int fullcnt = 1
) (
  input  logic [127:0]          state,
  input  logic [127:0]          key,
  input  logic [127:0]          tweak,
  input  logic [63+64*fullcnt:0] cnt,
  input  logic [6*numrnd-1:0]   round_const,
  output logic [127:0]          next_state,
  output logic [127:0]          next_key,
  output logic [127:0]          next_tweak,
  output logic [63+64*fullcnt:0] next_cnt
);
  localparam logic [63:0] PT = 64'h9F8DAECB01234567;
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] x;
    x = a;
    for (int r = 0; r < 4; r++) begin
      x = x ^ {3'b0, ~(x[7] | x[6]), 3'b0, ~(x[3] | x[2])};
      x = (r < 3) ? {x[2], x[1], x[7], x[6], x[4], x[0], x[3], x[5]} : {x[7:3], x[1], x[2], x[0]};
    end
    return x;
  endfunction
  function automatic logic [127:0] perm(input logic [127:0] t);
    logic [127:0] o;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = t[127-8*int'(PT[63-4*i -: 4]) -: 8];
    return o;
  endfunction
  function automatic logic [127:0] lfsr2(input logic [127:0] t);
    logic [127:0] o;
    o = t;
    for (int i = 0; i < 8; i++) o[127-8*i -: 8] = {t[126-8*i -: 7], t[127-8*i] ^ t[125-8*i]};
    return o;
  endfunction
  function automatic logic [127:0] lfsr3(input logic [127:0] t);
    logic [127:0] o;
    o = t;
    for (int i = 0; i < 8; i++) o[127-8*i -: 8] = {t[120-8*i] ^ t[126-8*i], t[127-8*i -: 7]};
    return o;
  endfunction
  // SubCells, constants, round tweakey on the top two rows, ShiftRows, then MixColumns on whole rows
  function automatic logic [127:0] rnd(input logic [127:0] s, input logic [127:0] tk, input logic [5:0] rc);
    logic [127:0] x;
    logic [31:0] r1, r2, r3;
    for (int i = 0; i < 16; i++) x[127-8*i -: 8] = sbox(s[127-8*i -: 8]);
    x = x ^ {4'h0, rc[3:0], 24'h0, 6'h0, rc[5:4], 24'h0, 8'h02, 56'h0} ^ {tk[127:64], 64'h0};
    r1 = {x[71:64], x[95:72]};
    r2 = {x[47:32], x[63:48]};
    r3 = {x[23:0], x[31:24]};
    return {x[127:96] ^ r2 ^ r3, x[127:96], r1 ^ r2, x[127:96] ^ r2};
  endfunction
  logic [127:0] s [numrnd+1];
  logic [127:0] k1 [numrnd+1];
  logic [127:0] k2 [numrnd+1];
  logic [127:0] k3 [numrnd+1];
  assign s[0] = state;
  assign k1[0] = 128'(cnt) << (64 - 64 * fullcnt);
  assign k2[0] = tweak;
  assign k3[0] = key;
  for (genvar i = 0; i < numrnd; i++) begin : g_rnd
    assign s[i+1]  = rnd(s[i], k1[i] ^ k2[i] ^ k3[i], round_const[6*i +: 6]);
    assign k1[i+1] = perm(k1[i]);
    assign k2[i+1] = lfsr2(perm(k2[i]));
    assign k3[i+1] = lfsr3(perm(k3[i]));
  end
  assign next_state = s[numrnd];
  assign next_key = k3[numrnd];
  assign next_tweak = k2[numrnd];
  assign next_cnt = k1[numrnd][127 -: 64+64*fullcnt];
endmodule

module skinny_tbc #(
  parameter int numrnd = 2,
  parameter int fullcnt = 1,
  parameter int rounds = 40
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [127:0]          key_in,
  input  logic [127:0]          tweak_in,
  input  logic [63+64*fullcnt:0] cnt_in,
  input  logic [127:0]          state_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [127:0]          state_out
);
  localparam int STEPS = rounds / numrnd;
  localparam int CTRW = STEPS > 1 ? $clog2(STEPS) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;
  fsm_t fsm, fsm_nxt;
  logic [127:0] blk, key, tweak, nxt_blk, nxt_key, nxt_tweak;
  logic [63+64*fullcnt:0] cnt, nxt_cnt;
  logic [5:0] lfsr;
  logic [5:0] lc [numrnd+1];
  logic [CTRW-1:0] ctr;
  logic [6*numrnd-1:0] round_const;
  assign lc[0] = lfsr;
  for (genvar i = 0; i < numrnd; i++) begin : g_lfsr
    assign lc[i+1] = {lc[i][4:0], lc[i][5] ^ lc[i][4] ^ 1'b1};
    assign round_const[6*i +: 6] = lc[i+1];
  end
  skinny_rnd #(.numrnd(numrnd), .fullcnt(fullcnt)) u_rnd (
    .state(blk), .key(key), .tweak(tweak), .cnt(cnt), .round_const(round_const),
    .next_state(nxt_blk), .next_key(nxt_key), .next_tweak(nxt_tweak), .next_cnt(nxt_cnt)
  );
  assign in_ready = fsm == IDLE;
  assign out_valid = fsm == DONE;
  assign state_out = blk;
  always_comb begin
    fsm_nxt = (fsm == IDLE && in_valid) ? RUN :
              (fsm == RUN && ctr == CTRW'(STEPS - 1)) ? DONE :
              (fsm == DONE && out_ready) ? IDLE : fsm;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm <= IDLE;
      blk <= '0;
      key <= '0;
      tweak <= '0;
      cnt <= '0;
      lfsr <= '0;
      ctr <= '0;
    end else begin
      fsm <= fsm_nxt;
      if (fsm == IDLE && in_valid) begin
        blk <= state_in;
        key <= key_in;
        tweak <= tweak_in;
        cnt <= cnt_in;
        lfsr <= '0;
        ctr <= '0;
      end else if (fsm == RUN) begin
        blk <= nxt_blk;
        key <= nxt_key;
        tweak <= nxt_tweak;
        cnt <= nxt_cnt;
        lfsr <= lc[numrnd];
        ctr <= ctr + CTRW'(1);
      end
    end
  end
endmodule

// File: tb/tb_skinny_tbc.sv
// tb_skinny_tbc: table-driven and randomized checks of skinny_tbc against a byte-level SKINNY-128-384+ model.
module tb_skinny_tbc;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, in_valid, in_ready, out_valid, out_ready;
  logic [127:0] key_in, tweak_in, cnt_in, state_in, state_out;
  int tests = 0, fails = 0, sweep_done = 0;
  bit sweep_go = 1'b0;
  logic [7:0] sb [256];
  logic [5:0] rcs [64];
  localparam int PTM [16] = '{9, 15, 8, 13, 10, 14, 12, 11, 0, 1, 2, 3, 4, 5, 6, 7};
  localparam int NR [5] = '{2, 1, 4, 8, 2};
  localparam int FC [5] = '{1, 1, 1, 1, 0};
  typedef struct {
    logic [127:0] key, tweak, cnt, pt, ct;
  } vec_t;
  vec_t vecs [5];

  skinny_tbc dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .key_in(key_in), .tweak_in(tweak_in), .cnt_in(cnt_in), .state_in(state_in),
    .out_valid(out_valid), .out_ready(out_ready), .state_out(state_out)
  );

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // 40-round SKINNY-128-384 on 4x4 byte matrices
  function automatic logic [127:0] model(input logic [127:0] k3v, input logic [127:0] k2v,
                                         input logic [127:0] k1v, input logic [127:0] pv);
    logic [7:0] s [16], a [16], b [16], c [16], tmp [16];
    logic [5:0] rc;
    logic [127:0] o;
    rc = '0;
    for (int i = 0; i < 16; i++) begin
      s[i] = pv[127-8*i -: 8];
      a[i] = k1v[127-8*i -: 8];
      b[i] = k2v[127-8*i -: 8];
      c[i] = k3v[127-8*i -: 8];
    end
    for (int r = 0; r < 40; r++) begin
      rc = {rc[4:0], ~(rc[5] ^ rc[4])};
      for (int i = 0; i < 16; i++) s[i] = sb[s[i]];
      s[0] ^= {4'h0, rc[3:0]};
      s[4] ^= {6'h0, rc[5:4]};
      s[8] ^= 8'h02;
      for (int i = 0; i < 8; i++) s[i] ^= a[i] ^ b[i] ^ c[i];
      tmp = a;
      for (int i = 0; i < 16; i++) a[i] = tmp[PTM[i]];
      tmp = b;
      for (int i = 0; i < 16; i++) b[i] = tmp[PTM[i]];
      tmp = c;
      for (int i = 0; i < 16; i++) c[i] = tmp[PTM[i]];
      for (int i = 0; i < 8; i++) begin
        b[i] = {b[i][6:0], b[i][7] ^ b[i][5]};
        c[i] = {c[i][0] ^ c[i][6], c[i][7:1]};
      end
      tmp = s;
      for (int q = 0; q < 4; q++)
        for (int j = 0; j < 4; j++) s[4*q+j] = tmp[4*q+(j+4-q)%4];
      for (int j = 0; j < 4; j++) begin
        s[4+j] ^= s[8+j];
        s[8+j] ^= s[j];
        s[12+j] ^= s[8+j];
      end
      tmp = s;
      for (int j = 0; j < 4; j++) begin
        s[j] = tmp[12+j];
        s[4+j] = tmp[j];
        s[8+j] = tmp[4+j];
        s[12+j] = tmp[8+j];
      end
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
    return o;
  endfunction

  task automatic run_main(input vec_t v);
    int k;
    logic [127:0] held;
    key_in = v.key;
    tweak_in = v.tweak;
    cnt_in = v.cnt;
    state_in = v.pt;
    in_valid = 1'b1;
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    k = 0;
    while (!out_valid && k < 30) begin
      if (k < 20) chk($sformatf("const_c%0d", k + 1), 256'(dut.round_const), 256'({rcs[2*k+2], rcs[2*k+1]}));
      @(negedge clk);
      k++;
    end
    chk("latency", k, 20);
    chk("ciphertext", state_out, v.ct);
    held = state_out;
    repeat (10) begin
      @(negedge clk);
      chk("backpressure", {in_ready, out_valid, state_out}, {2'b01, held});
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("release", {in_ready, out_valid}, 2'b10);
  endtask

  for (genvar g = 0; g < 5; g++) begin : g_sw
    localparam int N = NR[g];
    localparam int F = FC[g];
    localparam int CW = 64 + 64 * F;
    localparam int ST = 40 / N;
    logic iv, ir, ov, orr;
    logic [127:0] k, t, p, so;
    logic [CW-1:0] c;
    skinny_tbc #(.numrnd(N), .fullcnt(F), .rounds(40)) u (
      .clk(clk), .rst(rst), .in_valid(iv), .in_ready(ir), .key_in(k), .tweak_in(t),
      .cnt_in(c), .state_in(p), .out_valid(ov), .out_ready(orr), .state_out(so)
    );
    initial begin
      logic [127:0] kk [3], tt [3], cc [3], pp [3], ee [3];
      int acc [3];
      int na, nr;
      bit pend;
      iv = 1'b0;
      orr = 1'b1;
      k = '0;
      t = '0;
      p = '0;
      c = '0;
      wait (sweep_go);
      for (int j = 0; j < 3; j++) begin
        kk[j] = rand128();
        tt[j] = rand128();
        pp[j] = rand128();
        cc[j] = rand128();
        if (F == 0) cc[j][63:0] = '0;
        ee[j] = model(kk[j], tt[j], cc[j], pp[j]);
      end
      na = 0;
      nr = 0;
      pend = 1'b1;
      for (int cyc = 0; cyc < 3 * (ST + 2) + 20 && nr < 3; cyc++) begin
        @(negedge clk);
        if (pend) begin
          pend = 1'b0;
          if (na < 3) begin
            k = kk[na];
            t = tt[na];
            p = pp[na];
            c = cc[na][127 -: CW];
            iv = 1'b1;
          end else iv = 1'b0;
        end
        if (ov) begin
          chk($sformatf("sweep%0d_latency", g), cyc - acc[nr], ST + 1);
          chk($sformatf("sweep%0d_ct", g), so, ee[nr]);
          nr++;
        end
        if (iv && ir && na < 3) begin
          acc[na] = cyc;
          if (na > 0) chk($sformatf("sweep%0d_spacing", g), acc[na] - acc[na-1], ST + 2);
          na++;
          pend = 1'b1;
        end
      end
      chk($sformatf("sweep%0d_count", g), {na, nr}, {32'd3, 32'd3});
      sweep_done++;
    end
  end

  initial begin
    logic [5:0] r6;
    bit seen;
    for (int v = 0; v < 256; v++) begin
      logic [7:0] x, y;
      int pm [8], sw [8];
      pm = '{5, 3, 0, 4, 6, 7, 1, 2};
      sw = '{0, 2, 1, 3, 4, 5, 6, 7};
      x = v[7:0];
      for (int it = 0; it < 4; it++) begin
        x[4] = x[4] ^ ~(x[7] | x[6]);
        x[0] = x[0] ^ ~(x[3] | x[2]);
        y = x;
        for (int b = 0; b < 8; b++) x[b] = (it < 3) ? y[pm[b]] : y[sw[b]];
      end
      sb[v] = x;
    end
    r6 = '0;
    rcs[0] = '0;
    for (int i = 1; i < 64; i++) begin
      r6 = {r6[4:0], ~(r6[5] ^ r6[4])};
      rcs[i] = r6;
    end
    vecs[0] = '{default: '0};
    for (int i = 0; i < 16; i++) begin
      vecs[1].key[127-8*i -: 8] = 8'(i);
      vecs[1].tweak[127-8*i -: 8] = 8'(16 + i);
      vecs[1].cnt[127-8*i -: 8] = 8'(32 + i);
      vecs[1].pt[127-8*i -: 8] = 8'(48 + i);
    end
    for (int i = 2; i < 5; i++) begin
      vecs[i].key = rand128();
      vecs[i].tweak = rand128();
      vecs[i].cnt = rand128();
      vecs[i].pt = rand128();
    end
    for (int i = 0; i < 5; i++) vecs[i].ct = model(vecs[i].key, vecs[i].tweak, vecs[i].cnt, vecs[i].pt);
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    key_in = '0;
    tweak_in = '0;
    cnt_in = '0;
    state_in = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("reset_in_ready", in_ready, 1'b1);
    chk("reset_out_valid", out_valid, 1'b0);
    chk("reset_state_out", state_out, 128'h0);
    for (int i = 0; i < 5; i++) run_main(vecs[i]);
    key_in = vecs[3].key;
    tweak_in = vecs[3].tweak;
    cnt_in = vecs[3].cnt;
    state_in = vecs[3].pt;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrun_reset", {in_ready, out_valid, state_out}, {2'b10, 128'h0});
    seen = 1'b0;
    repeat (25) begin
      @(negedge clk);
      seen |= out_valid;
    end
    chk("midrun_no_valid", seen, 1'b0);
    run_main(vecs[1]);
    sweep_go = 1'b1;
    for (int i = 0; i < 600 && sweep_done < 5; i++) @(negedge clk);
    chk("sweep_finished", sweep_done, 5);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
